// File: rtl/dcache_repl_if.sv
// Request/hit/flush bundle and victim response of the data-cache replacement unit.
interface dcache_repl_if #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned NUM_SETS = 256
);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  // Victim request
  logic                req_i;
  logic [IDX_W-1:0]    req_idx_i;
  logic [NUM_WAYS-1:0] valid_i;
  // Hit notification
  logic                hit_i;
  logic [IDX_W-1:0]    hit_idx_i;
  logic [NUM_WAYS-1:0] hit_way_i;
  // Global state clear
  logic                flush_i;
  // Victim response
  logic                valid_o;
  logic [NUM_WAYS-1:0] victim_oh_o;
  logic [WAY_W-1:0]    victim_bin_o;
  logic                evict_o;

  // Cache controller side
  modport master (
    output req_i, req_idx_i, valid_i, hit_i, hit_idx_i, hit_way_i, flush_i,
    input  valid_o, victim_oh_o, victim_bin_o, evict_o
  );

  // Replacement unit side
  modport slave (
    input  req_i, req_idx_i, valid_i, hit_i, hit_idx_i, hit_way_i, flush_i,
    output valid_o, victim_oh_o, victim_bin_o, evict_o
  );
endinterface

// File: rtl/dcache_repl_unit.sv
// Data-cache victim selection: lowest invalid way first, otherwise a per-set round-robin
// pointer, a global 8-bit LFSR, or a per-set tree pseudo-LRU, chosen by REPL_MODE.
// Responses are registered one cycle after the request.
module dcache_repl_unit #(
  parameter int unsigned NUM_WAYS  = 4,
  parameter int unsigned NUM_SETS  = 256,
  parameter int unsigned REPL_MODE = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  dcache_repl_if.slave repl
);

  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned WAY_W  = $clog2(NUM_WAYS);
  localparam int unsigned TREE_W = NUM_WAYS - 1;
  localparam int unsigned NODE_W = WAY_W + 1;

  localparam logic [7:0] LfsrSeed = 8'hA5;

  typedef logic [WAY_W-1:0]    way_t;
  typedef logic [NUM_WAYS-1:0] oh_t;
  typedef logic [TREE_W-1:0]   tree_t;
  typedef logic [NODE_W-1:0]   node_t;

  // Tree nodes are heap-ordered: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic way_t plru_victim(input tree_t t);
    way_t  w;
    node_t node;
    tree_t sh;
    logic  b;
    w    = '0;
    node = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      sh   = t >> node;
      b    = sh[0];
      w    = (w << 1) | way_t'(b);
      node = (node << 1) + node_t'(1) + node_t'(b);
    end
    return w;
  endfunction

  // Point every node on the path to way w away from w.
  function automatic tree_t plru_touch(input tree_t t, input way_t w);
    tree_t res;
    tree_t mask;
    node_t node;
    way_t  sh;
    logic  wb;
    res  = t;
    node = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      sh   = w >> (int'(WAY_W) - 1 - l);
      wb   = sh[0];
      mask = tree_t'(1) << node;
      res  = wb ? (res & ~mask) : (res | mask);
      node = (node << 1) + node_t'(1) + node_t'(wb);
    end
    return res;
  endfunction

  // Replacement state
  logic [NUM_SETS-1:0][WAY_W-1:0]  ptr_q;
  logic [NUM_SETS-1:0][TREE_W-1:0] tree_q;
  logic [7:0]                      lfsr_q, lfsr_d;

  // Registered response
  logic rsp_valid_q, rsp_valid_d;
  oh_t  rsp_oh_q, rsp_oh_d;
  way_t rsp_bin_q, rsp_bin_d;
  logic rsp_evict_q, rsp_evict_d;

  // Combinational decode
  logic  all_valid;
  way_t  fill_bin;
  way_t  policy_bin;
  way_t  victim_bin;
  logic  hit_onehot;
  way_t  hit_bin;
  logic  ptr_upd;
  way_t  ptr_next;
  logic  tree_alloc_upd;
  tree_t tree_alloc;
  logic  tree_hit_upd;
  tree_t tree_hit_base;
  tree_t tree_hit;

  // Victim choice, state next values and response next values
  always_comb begin
    all_valid = &repl.valid_i;

    fill_bin = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!repl.valid_i[w]) fill_bin = way_t'(w);
    end

    unique case (REPL_MODE)
      0:       policy_bin = ptr_q[repl.req_idx_i];
      1:       policy_bin = lfsr_q[WAY_W-1:0];
      default: policy_bin = plru_victim(tree_q[repl.req_idx_i]);
    endcase
    victim_bin = all_valid ? policy_bin : fill_bin;

    hit_onehot = (repl.hit_way_i != '0) && ((repl.hit_way_i & (repl.hit_way_i - oh_t'(1))) == '0);
    hit_bin    = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (repl.hit_way_i[w]) hit_bin = way_t'(w);
    end

    ptr_upd  = repl.req_i && all_valid && (REPL_MODE == 0);
    ptr_next = ptr_q[repl.req_idx_i] + way_t'(1);

    lfsr_d = lfsr_q;
    if (repl.req_i && all_valid && (REPL_MODE == 1)) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Both fills and evictions count as accesses in the tree.
    tree_alloc_upd = repl.req_i && (REPL_MODE == 2);
    tree_alloc     = plru_touch(tree_q[repl.req_idx_i], victim_bin);

    // A same-set hit builds on the allocation result so the hit way ends most-recently-used.
    tree_hit_upd  = repl.hit_i && hit_onehot && (REPL_MODE == 2);
    tree_hit_base = (tree_alloc_upd && (repl.hit_idx_i == repl.req_idx_i)) ? tree_alloc
                                                                           : tree_q[repl.hit_idx_i];
    tree_hit      = plru_touch(tree_hit_base, hit_bin);

    rsp_valid_d = repl.req_i;
    rsp_bin_d   = repl.req_i ? victim_bin : '0;
    rsp_oh_d    = repl.req_i ? (oh_t'(1) << victim_bin) : '0;
    rsp_evict_d = repl.req_i && all_valid;
  end

  // Response register; a request seen during reset is dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_oh_q    <= '0;
      rsp_bin_q   <= '0;
      rsp_evict_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_oh_q    <= rsp_oh_d;
      rsp_bin_q   <= rsp_bin_d;
      rsp_evict_q <= rsp_evict_d;
    end
  end

  // LFSR keeps running across flushes; only reset reseeds it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Per-set pointers and tree bits; flush discards this cycle's updates
  always_ff @(posedge clk_i) begin
    if (rst_i || repl.flush_i) begin
      ptr_q  <= '0;
      tree_q <= '0;
    end else begin
      if (ptr_upd) ptr_q[repl.req_idx_i] <= ptr_next;
      if (tree_alloc_upd) tree_q[repl.req_idx_i] <= tree_alloc;
      // Last write wins when both target the same set; tree_hit already includes the fill.
      if (tree_hit_upd) tree_q[repl.hit_idx_i] <= tree_hit;
    end
  end

  assign repl.valid_o      = rsp_valid_q;
  assign repl.victim_oh_o  = rsp_oh_q;
  assign repl.victim_bin_o = rsp_bin_q;
  assign repl.evict_o      = rsp_evict_q;

endmodule

// File: tb/tb_dcache_repl_unit.sv
// Directed bench for dcache_repl_unit: one instance per replacement mode, a shared stimulus
// gated by a mode select, and a queue of expected responses popped one cycle later.
module tb_dcache_repl_unit;

  localparam int unsigned NW = 4;
  localparam int unsigned NS = 16;
  localparam logic [3:0]  F  = 4'b1111;

  typedef struct packed {
    logic [1:0] bin;
    logic       evict;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sel = 2'd2;
  logic       req = 1'b0;
  logic       hit = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] idx = '0;
  logic [3:0] hidx = '0;
  logic [3:0] vld = '0;
  logic [3:0] hway = '0;

  logic       o_v   [3];
  logic [3:0] o_oh  [3];
  logic [1:0] o_bin [3];
  logic       o_ev  [3];

  logic       obs_valid;
  logic [3:0] obs_oh;
  logic [1:0] obs_bin;
  logic       obs_evict;

  exp_t  sb [$];
  int    n_pass  = 0;
  int    n_total = 0;
  string step    = "reset";

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    dcache_repl_if #(.NUM_WAYS(NW), .NUM_SETS(NS)) bus ();

    assign bus.req_i     = req && (sel == 2'(k));
    assign bus.req_idx_i = idx;
    assign bus.valid_i   = vld;
    assign bus.hit_i     = hit && (sel == 2'(k));
    assign bus.hit_idx_i = hidx;
    assign bus.hit_way_i = hway;
    assign bus.flush_i   = flush && (sel == 2'(k));

    dcache_repl_unit #(
      .NUM_WAYS (NW),
      .NUM_SETS (NS),
      .REPL_MODE(k)
    ) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .repl (bus)
    );

    assign o_v[k]   = bus.valid_o;
    assign o_oh[k]  = bus.victim_oh_o;
    assign o_bin[k] = bus.victim_bin_o;
    assign o_ev[k]  = bus.evict_o;
  end

  always_comb begin
    obs_valid = 1'b0;
    obs_oh    = '0;
    obs_bin   = '0;
    obs_evict = 1'b0;
    case (sel)
      2'd0: begin obs_valid = o_v[0]; obs_oh = o_oh[0]; obs_bin = o_bin[0]; obs_evict = o_ev[0]; end
      2'd1: begin obs_valid = o_v[1]; obs_oh = o_oh[1]; obs_bin = o_bin[1]; obs_evict = o_ev[1]; end
      default: begin
        obs_valid = o_v[2]; obs_oh = o_oh[2]; obs_bin = o_bin[2]; obs_evict = o_ev[2];
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s.%s: observed %0h expected %0h", step, tag, act, exp);
  endtask

  // Drive a request and record the response it must produce.
  task automatic rq(input logic [3:0] i, input logic [3:0] v, input logic [1:0] eb,
                    input logic ee);
    req = 1'b1;
    idx = i;
    vld = v;
    sb.push_back('{bin: eb, evict: ee});
  endtask

  task automatic hi(input logic [3:0] i, input logic [3:0] w);
    hit  = 1'b1;
    hidx = i;
    hway = w;
  endtask

  // Advance one edge, release pulses, then compare against the scoreboard.
  task automatic tick();
    exp_t       e;
    logic [3:0] exp_oh;
    @(posedge clk);
    #1;
    req   = 1'b0;
    hit   = 1'b0;
    flush = 1'b0;
    hway  = '0;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      exp_oh = 4'b0001 << e.bin;
      chk("valid", 32'(obs_valid), 32'd1);
      chk("bin",   32'(obs_bin),   32'(e.bin));
      chk("oh",    32'(obs_oh),    32'(exp_oh));
      chk("evict", 32'(obs_evict), 32'(e.evict));
    end else begin
      chk("valid_idle", 32'(obs_valid), 32'd0);
      chk("oh_idle",    32'(obs_oh),    32'd0);
      chk("bin_idle",   32'(obs_bin),   32'd0);
      chk("evict_idle", 32'(obs_evict), 32'd0);
    end
  endtask

  initial begin
    // Request during reset must be dropped
    rst = 1'b1; sel = 2'd2; req = 1'b1; idx = 4'd3; vld = F;
    tick();
    tick();
    rst = 1'b0;

    // Tree PLRU walk on one set
    step = "plru_seq";
    rq(3, F, 2'd0, 1'b1); tick();
    rq(3, F, 2'd2, 1'b1); tick();
    rq(3, F, 2'd1, 1'b1); tick();
    rq(3, F, 2'd3, 1'b1); tick();
    rq(3, F, 2'd0, 1'b1); tick();

    step = "plru_hit";
    hi(5, 4'b0001); tick();
    rq(5, F, 2'd2, 1'b1); hi(5, 4'b0100); tick();
    rq(5, F, 2'd1, 1'b1); tick();

    // Allocation applied before same-cycle hit: way 3 would follow the opposite order
    step = "plru_order";
    rq(7, F, 2'd0, 1'b1); hi(7, 4'b0100); tick();
    rq(7, F, 2'd1, 1'b1); tick();

    step = "plru_xset";
    rq(8, F, 2'd0, 1'b1); hi(9, 4'b0001); tick();
    rq(9, F, 2'd2, 1'b1); tick();
    rq(8, F, 2'd2, 1'b1); tick();

    step = "plru_badhit";
    hi(10, 4'b0011); tick();
    rq(10, F, 2'd0, 1'b1); tick();

    step = "plru_fill";
    rq(11, 4'b1011, 2'd2, 1'b0); tick();
    rq(11, F, 2'd0, 1'b1); tick();

    step = "plru_flush";
    rq(12, F, 2'd0, 1'b1); tick();
    rq(12, F, 2'd2, 1'b1); tick();
    rq(12, F, 2'd1, 1'b1); flush = 1'b1; tick();
    rq(12, F, 2'd0, 1'b1); tick();
    rq(3, F, 2'd0, 1'b1); tick();

    // Reset overrides request, hit and flush
    step = "reset_ovr";
    rst = 1'b1; req = 1'b1; idx = 4'd12; vld = F; hi(12, 4'b0010); flush = 1'b1;
    tick();
    rst = 1'b0;
    rq(12, F, 2'd0, 1'b1); tick();

    // Round-robin: two sets interleaved keep independent pointers
    sel  = 2'd0;
    step = "rr_alt";
    for (int k = 0; k < 5; k++) begin
      rq(1, F, 2'(k % 4), 1'b1); tick();
      rq(2, F, 2'(k % 4), 1'b1); tick();
    end

    step = "rr_fill";
    rq(4, 4'b1011, 2'd2, 1'b0); tick();
    rq(4, F, 2'd0, 1'b1); tick();

    step = "rr_hit";
    hi(1, 4'b0010); tick();
    rq(1, F, 2'd1, 1'b1); tick();

    step = "rr_lowest";
    rq(6, 4'b0000, 2'd0, 1'b0); tick();
    rq(6, 4'b0111, 2'd3, 1'b0); tick();

    // LFSR: A5 -> 4A -> 95 -> 2A, fills do not advance it and flush leaves it alone
    sel  = 2'd1;
    step = "lfsr";
    rq(0, F, 2'd1, 1'b1); tick();
    rq(9, F, 2'd2, 1'b1); tick();
    rq(5, 4'b0111, 2'd3, 1'b0); tick();
    rq(5, F, 2'd1, 1'b1); tick();
    flush = 1'b1; tick();
    rq(2, F, 2'd2, 1'b1); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dcache_repl_unit.md
DCACHE_REPL_UNIT -- requirements
Module: dcache_repl_unit

Interface
REQ-001: Parameter NUM_WAYS, default 4, sets associativity; power of 2, range 2..16.
REQ-002: Parameter NUM_SETS, default 256, sets the number of sets; power of 2, at least 2.
REQ-003: Parameter REPL_MODE, default 2, selects the policy: 0 = per-set round-robin, 1 = LFSR, 2 = tree pseudo-LRU.
REQ-004: Port clk_i, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-005: Port rst_i, input, 1 bit, is the synchronous active-high reset.
REQ-006: Port req_i, input, 1 bit, requests a victim; it is accepted every cycle, with no backpressure.
REQ-007: Port req_idx_i, input, $clog2(NUM_SETS) bits, is the set index of the request.
REQ-008: Port valid_i, input, NUM_WAYS bits, gives the per-way valid bits of the requested set.
REQ-009: Port hit_i, input, 1 bit, reports a cache hit for replacement-state update.
REQ-010: Port hit_idx_i, input, $clog2(NUM_SETS) bits, is the set index of the hit.
REQ-011: Port hit_way_i, input, NUM_WAYS bits, is the one-hot hit way.
REQ-012: Port flush_i, input, 1 bit, clears all replacement state.
REQ-013: Port valid_o, output, 1 bit, marks a victim response.
REQ-014: Port victim_oh_o, output, NUM_WAYS bits, is the one-hot victim way.
REQ-015: Port victim_bin_o, output, $clog2(NUM_WAYS) bits, is the binary victim way.
REQ-016: Port evict_o, output, 1 bit, is high when all ways were valid, so the victim needs eviction.

Function
REQ-017: The block shall register the response, so valid_o rises exactly 1 cycle after req_i; back-to-back requests yield back-to-back responses.
REQ-018: If any valid_i bit is 0, the victim shall be the lowest-index invalid way and evict_o shall be 0.
REQ-019: If all valid_i bits are 1, the victim shall come from the REPL_MODE policy and evict_o shall be 1.
REQ-020: victim_oh_o shall always be one-hot when valid_o=1, and victim_bin_o shall equal its encoding.
REQ-021: While valid_o=0, victim_oh_o, victim_bin_o and evict_o shall be 0.
REQ-022: Mode 0 shall keep one $clog2(NUM_WAYS)-bit pointer per set.
- When the set has all ways valid: victim = pointer, then pointer increments modulo NUM_WAYS.
- Invalid-way fills leave the pointer unchanged.
REQ-023: Mode 1 shall use one global 8-bit Fibonacci LFSR.
- Seed: 8'hA5.
- Step: shift left, new bit0 = b7^b5^b4^b3.
- Victim = lfsr[$clog2(NUM_WAYS)-1:0]; the LFSR advances only on an all-valid request.
REQ-024: Mode 2 shall keep NUM_WAYS-1 tree bits per set.
- Victim walk from the root: bit 0 selects the lower half, bit 1 the upper half.
- An access to way w sets each bit on w's path to point away from w.
REQ-025: In mode 2, every response (fill or evict) and every hit_i shall count as an access to the chosen or hit way.
REQ-026: The victim shall be computed from state as it stood before the request cycle's edge, and state updates shall take effect at that same edge.
- A next-cycle request to the same set sees the updated state.
REQ-027: If a hit and an allocation target the same set in the same cycle, the block shall apply the allocation update first, then the hit update, so the hit way ends most-recently-used.
REQ-028: A hit to a different set from a same-cycle allocation shall update both sets independently.
REQ-029: On flush_i=1, the block shall return all pointers and tree bits to 0 at the next edge.
- The LFSR is not affected.
- A request in the flush cycle still gets its response, computed from pre-flush state.
- That request's state update is discarded.
REQ-030: hit_i with hit_way_i not one-hot shall be ignored in all modes (no state change).
REQ-031: Modes 0 and 1 shall ignore hit_i.

Reset
REQ-032: While rst_i=1 at an edge, the block shall clear all pointers and tree bits to 0.
REQ-033: While rst_i=1 at an edge, the block shall load the LFSR with 8'hA5.
REQ-034: While rst_i=1 at an edge, the block shall drive valid_o, victim_oh_o, victim_bin_o and evict_o to 0.
REQ-035: A request present during reset shall be dropped and produce no response.
REQ-036: Reset shall override flush_i, hit_i and req_i.

Verification (NUM_WAYS=4, NUM_SETS=16)
REQ-037: Mode 2, after reset, four requests to set 3 with valid_i=4'b1111 -> victim_bin_o sequence 0,2,1,3, then a fifth request gives 0, with evict_o=1 each time.
REQ-038: Any mode, valid_i=4'b1011 -> victim_oh_o=4'b0100, evict_o=0; in mode 0 a following all-valid request to the same set gives pointer 0.
REQ-039: Mode 0, alternate all-valid requests to sets 1 and 2 -> each set yields 0,1,2,3,0 independently.
REQ-040: Mode 1, after reset, two all-valid requests -> victims 1 then 2 (LFSR A5 then 4A).
REQ-041: Mode 2, set 5 after reset, hit_way_i=4'b0001 -> the next all-valid request gives victim 2; if the request and a hit to way 2 fall in the same cycle, the following request gives victim 1.
REQ-042: Reset and flush checks:
- req_i with rst_i=1 -> valid_o=0 next cycle.
- req_i with flush_i=1 in mode 2 after state 0,2 -> response victim 1, then the next request gives 0.
